// File: rtl/pc_sequencer_pkg.sv
// Shared PC-path constants and types used by the sequencer, control unit and ALU.
package pc_sequencer_pkg;

  localparam int unsigned PC_W_DEF         = 32;
  localparam int unsigned OFFSET_W_DEF     = 8;
  localparam int unsigned SHIFT_DEF        = 2;
  localparam int unsigned STEP_DEF         = 4;
  localparam int unsigned RESET_VECTOR_DEF = 0;
  localparam int unsigned CNT_W_DEF        = 8;

  // IDLE: no buffered redirect. PEND: a redirect target waits for busywait to drop.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer and its environment (control unit, ALU flag, I-cache).
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
);

  // Flow control: there is no valid/ready pair; busywait=1 means the memory
  // side cannot accept a new address, so pc must hold on that edge. A redirect
  // (branch_taken|jump) is qualified only by the edge at which it is sampled.
  logic                busywait;
  logic                branch_taken;
  logic                jump;
  logic [OFFSET_W-1:0] offset;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_next_seq;
  logic                redirect_pending;
  logic                target_wrap;
  logic [CNT_W-1:0]    stall_cycles;

  modport master (
    input  busywait, branch_taken, jump, offset,
    output pc, pc_next_seq, redirect_pending, target_wrap, stall_cycles
  );

  modport slave (
    output busywait, branch_taken, jump, offset,
    input  pc, pc_next_seq, redirect_pending, target_wrap, stall_cycles
  );

endinterface

// File: rtl/pc_sequencer_target_adder.sv
// Combinational branch/jump target: pc + step + (sign-extended offset << shift), with wrap flag.
module pc_sequencer_target_adder
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned SHIFT    = SHIFT_DEF,
  parameter int unsigned STEP     = STEP_DEF
) (
  input  logic [PC_W-1:0]     pc,
  input  logic [OFFSET_W-1:0] offset,
  output logic [PC_W-1:0]     target,
  output logic                wrap
);

  // Two guard bits hold the true signed sum: 01 = overflow past 2^PC_W, 11 = below zero.
  localparam int unsigned W2 = PC_W + 2;

  logic [W2-1:0] off_ext;
  logic [W2-1:0] sum;

  assign off_ext = {{(W2 - OFFSET_W){offset[OFFSET_W-1]}}, offset} << SHIFT;
  assign sum     = {2'b00, pc} + W2'(STEP) + off_ext;
  assign target  = sum[PC_W-1:0];
  assign wrap    = |sum[W2-1:PC_W];

endmodule

// File: rtl/pc_sequencer.sv
// PC register, sequential incrementer and stall-tolerant redirect buffer.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W         = PC_W_DEF,
  parameter int unsigned OFFSET_W     = OFFSET_W_DEF,
  parameter int unsigned SHIFT        = SHIFT_DEF,
  parameter int unsigned STEP         = STEP_DEF,
  parameter int unsigned RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        bus,
  output pc_state_e             state_dbg
);

  pc_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
  logic             pend_wrap_q, pend_wrap_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  target;
  logic             tgt_wrap;
  logic [PC_W-1:0]  pc_seq;
  logic [CNT_W-1:0] cnt_sat;
  logic             redirect;

  pc_sequencer_target_adder #(
    .PC_W     (PC_W),
    .OFFSET_W (OFFSET_W),
    .SHIFT    (SHIFT),
    .STEP     (STEP)
  ) u_target_adder (
    .pc     (pc_q),
    .offset (bus.offset),
    .target (target),
    .wrap   (tgt_wrap)
  );

  assign redirect = bus.branch_taken | bus.jump;
  assign pc_seq   = pc_q + PC_W'(STEP);
  assign cnt_sat  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_wrap_d = pend_wrap_q;
    wrap_d      = wrap_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.busywait) begin
          cnt_d = cnt_sat;
          if (redirect) begin
            pend_tgt_d  = target;
            pend_wrap_d = tgt_wrap;
            state_d     = ST_PEND;
          end
        end else begin
          cnt_d = '0;
          if (redirect) begin
            pc_d   = target;
            wrap_d = tgt_wrap;
          end else begin
            pc_d = pc_seq;
          end
        end
      end
      ST_PEND: begin
        // First captured target wins; live redirect inputs are ignored here.
        if (bus.busywait) begin
          cnt_d = cnt_sat;
        end else begin
          pc_d    = pend_tgt_q;
          wrap_d  = pend_wrap_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= PC_W'(RESET_VECTOR);
      pend_tgt_q  <= '0;
      pend_wrap_q <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_wrap_q <= pend_wrap_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_next_seq      = pc_seq;
  assign bus.redirect_pending = (state_q == ST_PEND);
  assign bus.target_wrap      = wrap_q;
  assign bus.stall_cycles     = cnt_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against an arithmetic reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic      clk;
  logic      rst;
  pc_state_e state_dbg;
  int        n_cmp;
  int        n_bad;

  pc_sequencer_if #(.PC_W(32), .OFFSET_W(8), .CNT_W(8)) bus ();

  pc_sequencer #(
    .PC_W(32), .OFFSET_W(8), .SHIFT(2), .STEP(4), .RESET_VECTOR(0), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam longint MOD = 64'sh1_0000_0000;
  longint m_pc;
  bit     m_pend;
  longint m_pend_pc;
  bit     m_pend_wrap;
  bit     m_wrap;
  int     m_stall;

  task automatic model_tick();
    longint so, sum, tgt;
    bit     w;
    bit     redir;
    so    = $signed(bus.offset);
    sum   = m_pc + 4 + so * 4;
    w     = (sum < 0) || (sum >= MOD);
    tgt   = (sum < 0) ? sum + MOD : ((sum >= MOD) ? sum - MOD : sum);
    redir = bus.branch_taken || bus.jump;
    if (rst) begin
      m_pc = 0; m_pend = 0; m_pend_pc = 0; m_pend_wrap = 0; m_wrap = 0; m_stall = 0;
    end else if (bus.busywait) begin
      m_stall = (m_stall < 255) ? m_stall + 1 : 255;
      if (!m_pend && redir) begin
        m_pend = 1; m_pend_pc = tgt; m_pend_wrap = w;
      end
    end else begin
      m_stall = 0;
      if (m_pend) begin
        m_pc = m_pend_pc; m_wrap = m_pend_wrap; m_pend = 0;
      end else if (redir) begin
        m_pc = tgt; m_wrap = w;
      end else begin
        m_pc = (m_pc + 4) % MOD;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic drive(input bit b, input bit br, input bit j, input logic [7:0] off);
    bus.busywait     = b;
    bus.branch_taken = br;
    bus.jump         = j;
    bus.offset       = off;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    cycle();
    n_cmp++; if (bus.pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b want 0", bus.redirect_pending); end
    n_cmp++; if (bus.stall_cycles !== 8'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
    n_cmp++; if (bus.target_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", bus.target_wrap); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_cmp++; if (bus.pc !== 32'(i * 4)) begin n_bad++; $display("FAIL freerun_pc: got %h want %h", bus.pc, 32'(i * 4)); end
      n_cmp++; if (bus.pc_next_seq !== 32'(i * 4 + 4)) begin n_bad++; $display("FAIL freerun_next: got %h want %h", bus.pc_next_seq, 32'(i * 4 + 4)); end
      n_cmp++; if (bus.stall_cycles !== 8'd0) begin n_bad++; $display("FAIL freerun_stall: got %0d want 0", bus.stall_cycles); end
    end
  endtask

  task automatic test_branch();
    cycle();
    n_cmp++; if (bus.pc !== 32'h10) begin n_bad++; $display("FAIL branch_start_pc: got %h want %h", bus.pc, 32'h10); end
    drive(0, 1, 0, 8'h03);
    cycle();
    n_cmp++; if (bus.pc !== 32'h20) begin n_bad++; $display("FAIL branch_fwd_pc: got %h want %h", bus.pc, 32'h20); end
    n_cmp++; if (bus.target_wrap !== 1'b0) begin n_bad++; $display("FAIL branch_fwd_wrap: got %b want 0", bus.target_wrap); end
    drive(0, 1, 0, 8'hFE);
    cycle();
    n_cmp++; if (bus.pc !== 32'h1C) begin n_bad++; $display("FAIL branch_bwd_pc: got %h want %h", bus.pc, 32'h1C); end
    n_cmp++; if (bus.target_wrap !== 1'b0) begin n_bad++; $display("FAIL branch_bwd_wrap: got %b want 0", bus.target_wrap); end
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic test_stall_redirect();
    repeat (9) cycle();
    n_cmp++; if (bus.pc !== 32'h40) begin n_bad++; $display("FAIL stall_start_pc: got %h want %h", bus.pc, 32'h40); end
    drive(1, 0, 1, 8'h02);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      n_cmp++; if (bus.pc !== 32'h40) begin n_bad++; $display("FAIL stall_hold_pc: got %h want %h", bus.pc, 32'h40); end
      n_cmp++; if (bus.redirect_pending !== 1'b1) begin n_bad++; $display("FAIL stall_pend: got %b want 1", bus.redirect_pending); end
      n_cmp++; if (bus.stall_cycles !== 8'(k)) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", bus.stall_cycles, k); end
    end
    drive(0, 0, 0, 8'h02);
    cycle();
    n_cmp++; if (bus.pc !== 32'h4C) begin n_bad++; $display("FAIL stall_release_pc: got %h want %h", bus.pc, 32'h4C); end
    n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_bad++; $display("FAIL stall_release_pend: got %b want 0", bus.redirect_pending); end
    n_cmp++; if (bus.stall_cycles !== 8'd0) begin n_bad++; $display("FAIL stall_release_cnt: got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_first_wins();
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    cycle();
    rst = 1'b0;
    drive(1, 1, 0, 8'h01);
    cycle();
    drive(1, 1, 0, 8'h7F);
    cycle();
    drive(0, 0, 0, 8'h7F);
    cycle();
    n_cmp++; if (bus.pc !== 32'h08) begin n_bad++; $display("FAIL first_wins_pc: got %h want %h", bus.pc, 32'h08); end
    n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_bad++; $display("FAIL first_wins_pend: got %b want 0", bus.redirect_pending); end
  endtask

  task automatic test_wrap_saturate();
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    cycle();
    rst = 1'b0;
    drive(0, 0, 1, 8'h80);
    cycle();
    n_cmp++; if (bus.pc !== 32'hFFFF_FE04) begin n_bad++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'hFFFF_FE04); end
    n_cmp++; if (bus.target_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_flag: got %b want 1", bus.target_wrap); end
    n_cmp++; if (bus.pc_next_seq !== 32'hFFFF_FE08) begin n_bad++; $display("FAIL wrap_next: got %h want %h", bus.pc_next_seq, 32'hFFFF_FE08); end
    drive(1, 0, 0, 8'h00);
    for (int k = 1; k <= 300; k++) begin
      cycle();
      n_cmp++; if (bus.stall_cycles !== 8'((k > 255) ? 255 : k)) begin n_bad++; $display("FAIL sat_count: got %0d want %0d", bus.stall_cycles, (k > 255) ? 255 : k); end
    end
    n_cmp++; if (bus.pc !== 32'hFFFF_FE04) begin n_bad++; $display("FAIL sat_hold_pc: got %h want %h", bus.pc, 32'hFFFF_FE04); end
    drive(0, 0, 0, 8'h00);
    cycle();
    n_cmp++; if (bus.stall_cycles !== 8'd0) begin n_bad++; $display("FAIL sat_release_cnt: got %0d want 0", bus.stall_cycles); end
    n_cmp++; if (bus.pc !== 32'hFFFF_FE08) begin n_bad++; $display("FAIL sat_release_pc: got %h want %h", bus.pc, 32'hFFFF_FE08); end
    n_cmp++; if (bus.target_wrap !== 1'b1) begin n_bad++; $display("FAIL seq_keeps_wrap: got %b want 1", bus.target_wrap); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 1, 8'h10);
    cycle();
    n_cmp++; if (bus.redirect_pending !== 1'b1) begin n_bad++; $display("FAIL rms_pend_set: got %b want 1", bus.redirect_pending); end
    rst = 1'b1;
    cycle();
    n_cmp++; if (bus.pc !== 32'h0) begin n_bad++; $display("FAIL rms_pc: got %h want %h", bus.pc, 32'h0); end
    n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_bad++; $display("FAIL rms_pend: got %b want 0", bus.redirect_pending); end
    n_cmp++; if (bus.stall_cycles !== 8'd0) begin n_bad++; $display("FAIL rms_stall: got %0d want 0", bus.stall_cycles); end
    n_cmp++; if (bus.target_wrap !== 1'b0) begin n_bad++; $display("FAIL rms_wrap: got %b want 0", bus.target_wrap); end
    rst = 1'b0;
    drive(0, 0, 0, 8'h10);
    cycle();
    n_cmp++; if (bus.pc !== 32'h4) begin n_bad++; $display("FAIL rms_release_pc: got %h want %h", bus.pc, 32'h4); end
  endtask

  task automatic test_random();
    pc_state_e exp_state;
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 6) == 0, 8'($urandom_range(0, 255)));
      cycle();
      exp_state = m_pend ? ST_PEND : ST_IDLE;
      n_cmp++; if (bus.pc !== 32'(m_pc)) begin n_bad++; $display("FAIL rnd_pc @%0d: got %h want %h", n, bus.pc, 32'(m_pc)); end
      n_cmp++; if (bus.pc_next_seq !== 32'((m_pc + 4) % MOD)) begin n_bad++; $display("FAIL rnd_next @%0d: got %h want %h", n, bus.pc_next_seq, 32'((m_pc + 4) % MOD)); end
      n_cmp++; if (bus.redirect_pending !== m_pend) begin n_bad++; $display("FAIL rnd_pend @%0d: got %b want %b", n, bus.redirect_pending, m_pend); end
      n_cmp++; if (bus.target_wrap !== m_wrap) begin n_bad++; $display("FAIL rnd_wrap @%0d: got %b want %b", n, bus.target_wrap, m_wrap); end
      n_cmp++; if (bus.stall_cycles !== 8'(m_stall)) begin n_bad++; $display("FAIL rnd_stall @%0d: got %0d want %0d", n, bus.stall_cycles, m_stall); end
      n_cmp++; if (state_dbg !== exp_state) begin n_bad++; $display("FAIL rnd_state @%0d: got %0d want %0d", n, state_dbg, exp_state); end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_pc = 0; m_pend = 0; m_pend_pc = 0; m_pend_wrap = 0; m_wrap = 0; m_stall = 0;
    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_branch();
    test_stall_redirect();
    test_first_wins();
    test_wrap_saturate();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the dedicated PC-offset adder: owns the PC register, the +STEP incrementer and the branch/jump target adder.
- Stalls on memory BUSYWAIT and buffers a redirect that resolves during a stall, so no taken branch is lost.
- Sits between the control unit/ALU zero flag and the instruction cache address port; replaces the separate PC register, +4 adder and offset adder.

Parameters:
- PC_W, 32, PC and target width in bits.
- OFFSET_W, 8, width of the signed instruction offset field.
- SHIFT, 2, left shift applied to the offset (word alignment).
- STEP, 4, sequential increment in bytes.
- RESET_VECTOR, 0, PC value loaded on reset.
- CNT_W, 8, width of the stall counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUSYWAIT  in  1  high = memory hierarchy stalled, PC must hold.
- BRANCH_TAKEN  in  1  conditional branch resolved taken for the instruction at PC.
- JUMP  in  1  unconditional jump for the instruction at PC.
- OFFSET  in  OFFSET_W  signed offset for the instruction at PC.
- PC  out  PC_W  current instruction address, registered.
- PC_NEXT_SEQ  out  PC_W  PC + STEP, combinational from PC.
- REDIRECT_PENDING  out  1  a buffered redirect is waiting for BUSYWAIT to drop, registered.
- TARGET_WRAP  out  1  last committed redirect target wrapped modulo 2^PC_W, registered.
- STALL_CYCLES  out  CNT_W  stall cycles on the current PC, saturating, registered.

Behaviour:
- Clock and reset: one clock (CLK); reset is synchronous and active-high (RESET).
- Reset: on a CLK edge with RESET=1, all registered outputs load their reset values: PC=RESET_VECTOR, REDIRECT_PENDING=0, pending target=0, TARGET_WRAP=0, STALL_CYCLES=0. RESET overrides every other input, including a stall with a redirect pending; the pending redirect is discarded.
- Target arithmetic:
  - target = PC + STEP + (sign-extended OFFSET << SHIFT), computed modulo 2^PC_W.
  - Wrap = carry/borrow out of PC_W bits, i.e. the true signed sum is outside [0, 2^PC_W).
  - redirect = BRANCH_TAKEN | JUMP. When both are high, the result is the same target.
- State: IDLE (REDIRECT_PENDING=0) and PEND (REDIRECT_PENDING=1), plus a pending-target register.
- IDLE, BUSYWAIT=1:
  - PC holds; STALL_CYCLES increments, saturating at 2^CNT_W-1.
  - If redirect=1: capture target and its wrap bit, go to PEND.
- IDLE, BUSYWAIT=0:
  - redirect=1: PC<=target, TARGET_WRAP<=wrap.
  - otherwise: PC<=PC+STEP (modulo 2^PC_W; TARGET_WRAP unchanged).
  - STALL_CYCLES<=0.
- PEND, BUSYWAIT=1:
  - PC holds; STALL_CYCLES increments (saturating).
  - New redirect inputs are ignored (first capture wins; the inputs stay asserted through the stall).
- PEND, BUSYWAIT=0:
  - PC<=pending target, TARGET_WRAP<=pending wrap, STALL_CYCLES<=0, go to IDLE.
  - Live redirect inputs in this cycle are ignored.
- Latency:
  - Without a stall, a redirect takes effect at the next CLK edge (one cycle).
  - With a stall, it takes effect at the first edge where BUSYWAIT=0.
- PC_NEXT_SEQ updates combinationally whenever PC changes.
- No X propagation: all registers are explicitly assigned on every branch of the sequential logic.

Decomposition:
- Shared package/header `pc_defs`: RESET_VECTOR, STEP, SHIFT defaults and the OFFSET_W/PC_W constants shared with the control unit and ALU.
- One sub-module is natural: `pc_target_adder`, combinational, sign-extend + shift + add with a wrap output, parametrised by PC_W/OFFSET_W/SHIFT.
- The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
- Reset then free-run: RESET=1 for 1 edge, then BUSYWAIT=0 and no redirect for 3 edges -> PC = 0, 4, 8, 12; STALL_CYCLES=0 throughout.
- Forward/backward branch: at PC=0x10, BRANCH_TAKEN=1 with OFFSET=8'h03 -> next PC=0x20. At PC=0x20, OFFSET=8'hFE -> next PC=0x1C. TARGET_WRAP=0 in both cases.
- Redirect during stall: at PC=0x40, BUSYWAIT=1 for 3 edges with JUMP=1 and OFFSET=8'h02 -> PC holds at 0x40, REDIRECT_PENDING=1 from the first edge, STALL_CYCLES=1, 2, 3. Then BUSYWAIT=0 with JUMP=0 -> PC=0x4C, REDIRECT_PENDING=0, STALL_CYCLES=0.
- First-wins capture: during a stall, OFFSET changes from 8'h01 to 8'h7F while BRANCH_TAKEN=1 at PC=0x00 -> on release PC=0x08, not 0x200.
- Wrap and saturation:
  - PC=0x0, OFFSET=8'h80, JUMP=1 -> PC=0xFFFFFE04, TARGET_WRAP=1.
  - BUSYWAIT=1 held for 300 cycles -> STALL_CYCLES saturates at 255.
- Reset mid-stall: REDIRECT_PENDING=1 and BUSYWAIT=1, assert RESET -> at that edge PC=0, REDIRECT_PENDING=0, STALL_CYCLES=0. After release with BUSYWAIT=0 -> PC=4, and the old target is never loaded.
